// File: rtl/round_sequencer_pkg.sv
// Shared types and default constants for the round sequencer.
package round_sequencer_pkg;

   localparam int unsigned DEF_INIT_LIVES   = 3;
   localparam int unsigned DEF_MAX_STAGE    = 8;
   localparam int unsigned DEF_PAUSE_FRAMES = 60;
   localparam int unsigned DEF_AUTO_FRAMES  = 180;

   localparam int unsigned LIFE_W  = 3;
   localparam int unsigned STAGE_W = 4;
   localparam int unsigned STATE_W = 3;
   localparam int unsigned CNT_W   = 8;

   typedef enum logic [STATE_W-1:0] {
      StIdle  = 3'd0,
      StLoad  = 3'd1,
      StServe = 3'd2,
      StPlay  = 3'd3,
      StLost  = 3'd4,
      StClear = 3'd5,
      StOver  = 3'd6
   } state_e;

   // Life decrement that sticks at zero.
   function automatic logic [LIFE_W-1:0] sat_dec(input logic [LIFE_W-1:0] v);
      return (v == '0) ? '0 : v - 1'b1;
   endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Game-controller side bundle: event pulses in, sequencer status out.
interface round_sequencer_if;
   import round_sequencer_pkg::*;

   logic               i_frame_tick;
   logic               i_game_start;
   logic               i_life_loss;
   logic               i_stage_clear;
   logic               i_shoot;
   logic [LIFE_W-1:0]  o_life_count;
   logic [STAGE_W-1:0] o_stage;
   logic               o_brick_load;
   logic               o_ball_hold;
   logic               o_ball_launch;
   logic               o_game_over;
   logic               o_win;
   logic [STATE_W-1:0] o_state;

   modport master (
      output i_frame_tick, i_game_start, i_life_loss, i_stage_clear, i_shoot,
      input  o_life_count, o_stage, o_brick_load, o_ball_hold, o_ball_launch,
             o_game_over, o_win, o_state
   );

   modport slave (
      input  i_frame_tick, i_game_start, i_life_loss, i_stage_clear, i_shoot,
      output o_life_count, o_stage, o_brick_load, o_ball_hold, o_ball_launch,
             o_game_over, o_win, o_state
   );

endinterface

// File: rtl/round_sequencer_frame_timer.sv
// Saturating frame-tick counter with a >= target done flag.
module round_sequencer_frame_timer
   import round_sequencer_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clear,
   input  logic             i_tick,
   input  logic [CNT_W-1:0] i_target,
   output logic             o_done
);

   logic [CNT_W-1:0] cnt_q;

   // Count ticks; clear wins over tick, and the count sticks at all-ones.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else if (i_clear) begin
         cnt_q <= '0;
      end else if (i_tick && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign o_done = (cnt_q >= i_target);

endmodule

// File: rtl/round_sequencer.sv
// Game round sequencer: start, serve, play, life loss, stage clear, game over.
module round_sequencer
   import round_sequencer_pkg::*;
#(
   parameter int unsigned INIT_LIVES   = DEF_INIT_LIVES,
   parameter int unsigned MAX_STAGE    = DEF_MAX_STAGE,
   parameter int unsigned PAUSE_FRAMES = DEF_PAUSE_FRAMES,
   parameter int unsigned AUTO_FRAMES  = DEF_AUTO_FRAMES
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   round_sequencer_if.slave   bus
);

   state_e             state_q, state_d;
   logic [LIFE_W-1:0]  life_q, life_d;
   logic [STAGE_W-1:0] stage_q, stage_d;
   logic               over_q, over_d;
   logic               win_q, win_d;
   logic               brick_q, brick_d;
   logic               hold_q, hold_d;
   logic               launch_q, launch_d;

   logic               timer_clear;
   logic               timer_done;
   logic [CNT_W-1:0]   timer_target;

   // Restart the timer on every state change so SERVE/LOST/CLEAR start from zero.
   assign timer_clear  = (state_d != state_q);
   assign timer_target = (state_q == StServe) ? CNT_W'(AUTO_FRAMES) : CNT_W'(PAUSE_FRAMES);

   round_sequencer_frame_timer u_frame_timer (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clear  (timer_clear),
      .i_tick   (bus.i_frame_tick),
      .i_target (timer_target),
      .o_done   (timer_done)
   );

   // Next-state and next-output decode; outputs are registered below.
   always_comb begin
      state_d  = state_q;
      life_d   = life_q;
      stage_d  = stage_q;
      over_d   = over_q;
      win_d    = win_q;
      brick_d  = 1'b0;
      hold_d   = 1'b0;
      launch_d = 1'b0;
      case (state_q)
         StIdle, StOver: begin
            if (bus.i_game_start) begin
               state_d = StLoad;
               life_d  = LIFE_W'(INIT_LIVES);
               stage_d = STAGE_W'(1);
               over_d  = 1'b0;
               win_d   = 1'b0;
               brick_d = 1'b1;
            end
         end
         StLoad: begin
            state_d = StServe;
            hold_d  = 1'b1;
         end
         StServe: begin
            if (bus.i_shoot || timer_done) begin
               state_d  = StPlay;
               launch_d = 1'b1;
            end else begin
               hold_d = 1'b1;
            end
         end
         StPlay: begin
            // A clear in the same cycle as a loss takes priority and keeps the life.
            if (bus.i_stage_clear) begin
               state_d = StClear;
            end else if (bus.i_life_loss) begin
               state_d = StLost;
               life_d  = sat_dec(life_q);
            end
         end
         StLost: begin
            if (timer_done) begin
               if (life_q == '0) begin
                  state_d = StOver;
                  over_d  = 1'b1;
               end else begin
                  state_d = StServe;
                  hold_d  = 1'b1;
               end
            end
         end
         StClear: begin
            if (timer_done) begin
               if (stage_q == STAGE_W'(MAX_STAGE)) begin
                  state_d = StOver;
                  over_d  = 1'b1;
                  win_d   = 1'b1;
               end else begin
                  state_d = StLoad;
                  stage_d = stage_q + 1'b1;
                  brick_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= StIdle;
         life_q   <= '0;
         stage_q  <= '0;
         over_q   <= 1'b0;
         win_q    <= 1'b0;
         brick_q  <= 1'b0;
         hold_q   <= 1'b0;
         launch_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         life_q   <= life_d;
         stage_q  <= stage_d;
         over_q   <= over_d;
         win_q    <= win_d;
         brick_q  <= brick_d;
         hold_q   <= hold_d;
         launch_q <= launch_d;
      end
   end

   assign bus.o_life_count  = life_q;
   assign bus.o_stage       = stage_q;
   assign bus.o_brick_load  = brick_q;
   assign bus.o_ball_hold   = hold_q;
   assign bus.o_ball_launch = launch_q;
   assign bus.o_game_over   = over_q;
   assign bus.o_win         = win_q;
   assign bus.o_state       = state_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Randomized game-play bench with an event scoreboard for round_sequencer.
module tb_round_sequencer;
   import round_sequencer_pkg::*;

   localparam int INIT  = 3;
   localparam int MAXS  = 8;
   localparam int PAUSE = 60;
   localparam int AUTO  = 180;

   typedef enum int {EvLoad, EvServe, EvLaunch, EvOver} ev_kind_e;
   typedef struct {
      ev_kind_e kind;
      int       life;
      int       stage;
      int       win;
      int       ticks;   // -1: launched by shoot, must be before AUTO
      int       pause;
   } ev_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   round_sequencer_if bus ();

   round_sequencer #(
      .INIT_LIVES   (INIT),
      .MAX_STAGE    (MAXS),
      .PAUSE_FRAMES (PAUSE),
      .AUTO_FRAMES  (AUTO)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  m_lives;
   int  m_stage;
   int  serve_ticks;
   int  pause_ticks;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic ev_t mk(input ev_kind_e k, input int life, input int stage,
                              input int win, input int ticks, input int pause);
      ev_t e;
      e.kind = k; e.life = life; e.stage = stage; e.win = win; e.ticks = ticks; e.pause = pause;
      return e;
   endfunction

   // Free-running frame tick, one pulse every third cycle.
   initial begin
      int phase = 0;
      bus.i_frame_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.i_frame_tick = (phase == 0);
         phase = (phase + 1) % 3;
      end
   end

   task automatic handle_ev(input ev_kind_e k);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event: got %s, expected none", k.name());
      end else begin
         e = exp_q.pop_front();
         check("event_kind", int'(k), int'(e.kind));
         check({k.name(), "_life"}, int'(bus.o_life_count), e.life);
         check({k.name(), "_stage"}, int'(bus.o_stage), e.stage);
         check({k.name(), "_win"}, int'(bus.o_win), e.win);
         check({k.name(), "_game_over"}, int'(bus.o_game_over), (k == EvOver) ? 1 : 0);
         check({k.name(), "_pause_ticks"}, pause_ticks, e.pause);
         if (k == EvLaunch) begin
            if (e.ticks >= 0) check("auto_launch_ticks", serve_ticks, e.ticks);
            else              check("shoot_before_auto", int'(serve_ticks < AUTO), 1);
         end
      end
      pause_ticks = 0;
   endtask

   // Monitor: detects output events mid-cycle and compares against the queue.
   initial begin
      bit prev_brick = 0, prev_launch = 0, prev_hold = 0, prev_over = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_brick = 0; prev_launch = 0; prev_hold = 0; prev_over = 0;
            serve_ticks = 0; pause_ticks = 0;
         end else begin
            if (bus.o_ball_hold && !prev_hold) serve_ticks = 0;
            if (bus.o_ball_hold && bus.i_frame_tick) serve_ticks++;
            if ((bus.o_state == StLost || bus.o_state == StClear) && bus.i_frame_tick)
               pause_ticks++;
            if (bus.o_brick_load || bus.o_ball_launch)
               check("pulse_spacing", int'((bus.o_brick_load && prev_launch) ||
                                           (bus.o_ball_launch && prev_brick)), 0);
            if (bus.o_brick_load)                 handle_ev(EvLoad);
            if (bus.o_ball_hold && !prev_hold)    handle_ev(EvServe);
            if (bus.o_ball_launch)                handle_ev(EvLaunch);
            if (bus.o_game_over && !prev_over)    handle_ev(EvOver);
            prev_brick  = bus.o_brick_load;
            prev_launch = bus.o_ball_launch;
            prev_hold   = bus.o_ball_hold;
            prev_over   = bus.o_game_over;
         end
      end
   end

   task automatic drive_pulse(input bit start, input bit loss, input bit clr, input bit shoot);
      @(posedge clk);
      #1;
      bus.i_game_start = start; bus.i_life_loss = loss;
      bus.i_stage_clear = clr;  bus.i_shoot = shoot;
      @(posedge clk);
      #1;
      bus.i_game_start = 0; bus.i_life_loss = 0; bus.i_stage_clear = 0; bus.i_shoot = 0;
   endtask

   // which: 0 hold high, 1 launch pulse, 2 hold or game over
   task automatic wait_cond(input int which, input string name);
      int n;
      bit hit;
      hit = 0;
      for (n = 0; n < 3000 && !hit; n++) begin
         @(negedge clk);
         case (which)
            0:       hit = bus.o_ball_hold;
            1:       hit = bus.o_ball_launch;
            default: hit = bus.o_ball_hold || bus.o_game_over;
         endcase
      end
      if (!hit) begin
         checks++;
         errors++;
         $display("FAIL timeout_%s: got no event within %0d cycles, expected one", name, n);
      end
   endtask

   task automatic start_game();
      m_lives = INIT;
      m_stage = 1;
      exp_q.push_back(mk(EvLoad, m_lives, m_stage, 0, 0, 0));
      exp_q.push_back(mk(EvServe, m_lives, m_stage, 0, 0, 0));
      drive_pulse(1, 0, 0, 0);
      wait_cond(0, "serve_after_start");
   endtask

   task automatic serve(input bit force_auto);
      bit auto_l;
      auto_l = force_auto || ($urandom_range(0, 3) == 0);
      exp_q.push_back(mk(EvLaunch, m_lives, m_stage, 0, auto_l ? AUTO : -1, 0));
      if (!auto_l) begin
         if ($urandom_range(0, 3) == 0) drive_pulse(0, 1, 1, 0);  // ignored in SERVE
         repeat ($urandom_range(0, 100)) @(posedge clk);
         drive_pulse(0, 0, 0, 1);
      end
      wait_cond(1, "launch");
   endtask

   // action: 0 loss, 1 clear, 2 both
   task automatic play(input int action, output bit over);
      bit loss, clr;
      loss = (action != 1);
      clr  = (action != 0);
      over = 0;
      repeat ($urandom_range(1, 20)) @(posedge clk);
      if ($urandom_range(0, 2) == 0) drive_pulse(1, 0, 0, 1);  // ignored in PLAY
      if (clr) begin
         if (m_stage == MAXS) begin
            exp_q.push_back(mk(EvOver, m_lives, m_stage, 1, 0, PAUSE));
            over = 1;
         end else begin
            m_stage++;
            exp_q.push_back(mk(EvLoad, m_lives, m_stage, 0, 0, PAUSE));
            exp_q.push_back(mk(EvServe, m_lives, m_stage, 0, 0, 0));
         end
      end else begin
         m_lives = (m_lives > 0) ? m_lives - 1 : 0;
         if (m_lives == 0) begin
            exp_q.push_back(mk(EvOver, m_lives, m_stage, 0, 0, PAUSE));
            over = 1;
         end else begin
            exp_q.push_back(mk(EvServe, m_lives, m_stage, 0, 0, PAUSE));
         end
      end
      drive_pulse(0, loss, clr, 0);
      wait_cond(2, "pause_end");
   endtask

   // mode: 0 always lose, 1 aim to win, 2 random
   task automatic run_game(input int mode);
      bit over, first, won;
      int action;
      start_game();
      first = 1;
      over  = 0;
      won   = 0;
      while (!over) begin
         serve(mode == 0 && first);
         first = 0;
         case (mode)
            0: action = 0;
            1: action = (m_lives > 1 && $urandom_range(0, 4) == 0) ? 0 :
                        ($urandom_range(0, 2) == 0 ? 2 : 1);
            default: action = $urandom_range(0, 4) % 3;
         endcase
         if (action != 0 && m_stage == MAXS) won = 1;
         play(action, over);
      end
      // OVER must hold and ignore play inputs.
      drive_pulse(0, 1, 1, 1);
      repeat (5) @(negedge clk);
      check("over_hold", int'(bus.o_game_over), 1);
      check("over_win", int'(bus.o_win), int'(won));
      check("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      bus.i_game_start = 0; bus.i_life_loss = 0; bus.i_stage_clear = 0; bus.i_shoot = 0;
      repeat (3) @(negedge clk);
      check("rst_state", int'(bus.o_state), int'(StIdle));
      check("rst_life", int'(bus.o_life_count), 0);
      check("rst_stage", int'(bus.o_stage), 0);
      check("rst_pulses", int'({bus.o_brick_load, bus.o_ball_hold, bus.o_ball_launch,
                                bus.o_game_over, bus.o_win}), 0);
      rst_n = 1;
      // IDLE ignores play inputs.
      drive_pulse(0, 1, 1, 1);
      repeat (4) @(negedge clk);
      check("idle_ignores", int'(bus.o_state), int'(StIdle));

      run_game(0);
      run_game(1);
      run_game(2);

      // Reset in the middle of a LOST pause.
      start_game();
      serve(0);
      drive_pulse(0, 1, 0, 0);
      repeat (30) @(posedge clk);
      #3;
      rst_n = 0;
      exp_q.delete();
      #1;
      check("midlost_state", int'(bus.o_state), int'(StIdle));
      check("midlost_life", int'(bus.o_life_count), 0);
      check("midlost_stage", int'(bus.o_stage), 0);
      check("midlost_pulses", int'({bus.o_brick_load, bus.o_ball_hold, bus.o_ball_launch,
                                    bus.o_game_over, bus.o_win}), 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (20) @(negedge clk);
      check("post_rst_idle", int'(bus.o_state), int'(StIdle));

      run_game(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish by 2000000, expected earlier finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameter INIT_LIVES, default 3, lives loaded at game start (1..7).
REQ-002 Parameter MAX_STAGE, default 8, final stage number (1..15).
REQ-003 Parameter PAUSE_FRAMES, default 60, frame ticks spent in LOST and CLEAR (1..255).
REQ-004 Parameter AUTO_FRAMES, default 180, frame ticks in SERVE before auto-launch (1..255).
REQ-005 i_clk  in  1  sole clock, all state updates on rising edge.
REQ-006 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 i_frame_tick  in  1  one-cycle pulse per video frame.
REQ-008 i_game_start  in  1  one-cycle pulse, start request from game controller.
REQ-009 i_life_loss  in  1  one-cycle pulse, ball fell below platform.
REQ-010 i_stage_clear  in  1  one-cycle pulse, last brick destroyed.
REQ-011 i_shoot  in  1  gamepad launch level, sampled per cycle.
REQ-012 o_life_count  out  3  remaining lives.
REQ-013 o_stage  out  4  current stage, 1-based.
REQ-014 o_brick_load  out  1  one-cycle pulse, brick field reload for o_stage.
REQ-015 o_ball_hold  out  1  high while ball is held on platform.
REQ-016 o_ball_launch  out  1  one-cycle pulse, release ball.
REQ-017 o_game_over  out  1  level, game ended (lives exhausted or won).
REQ-018 o_win  out  1  level, valid with o_game_over, final stage cleared.
REQ-019 o_state  out  3  current state encoding, for display/debug.

Function
REQ-020 States IDLE, LOAD, SERVE, PLAY, LOST, CLEAR, OVER; all outputs registered.
REQ-021 IDLE: i_game_start -> LOAD next cycle; o_life_count<=INIT_LIVES, o_stage<=1, o_game_over<=0, o_win<=0.
REQ-022 LOAD: exactly one cycle; o_brick_load high during it; -> SERVE.
REQ-023 SERVE: o_ball_hold=1; frame counter cleared on entry, +1 per i_frame_tick.
REQ-024 SERVE: i_shoot=1 or counter reaching AUTO_FRAMES -> PLAY; o_ball_launch pulses the single cycle of transition; o_ball_hold drops same cycle.
REQ-025 PLAY: i_stage_clear -> CLEAR; i_life_loss -> LOST; both same cycle -> CLEAR, life kept.
REQ-026 LOST: on entry o_life_count decremented by 1 (saturating at 0); after PAUSE_FRAMES ticks -> OVER if count 0, else SERVE (no brick reload).
REQ-027 CLEAR: after PAUSE_FRAMES ticks -> OVER with o_win=1 if o_stage==MAX_STAGE, else o_stage+1 and -> LOAD.
REQ-028 OVER: o_game_over=1; i_game_start -> LOAD with full re-initialisation per REQ-021.
REQ-029 i_shoot, i_life_loss, i_stage_clear ignored outside the states naming them; i_game_start ignored outside IDLE/OVER.
REQ-030 Frame counter 8 bits, compares >= target, never wraps.
REQ-031 o_ball_launch and o_brick_load never high in consecutive cycles.

Reset
REQ-032 Async assert: state IDLE, o_life_count=0, o_stage=0, all pulses/levels 0, counter 0, regardless of current state.
REQ-033 Deassert: first evaluation on next rising i_clk; no spurious pulses.

Structure
REQ-034 Shared package holds state enum (3-bit) and default parameter constants.
REQ-035 One sub-module natural: frame_timer (clear, tick, target, done).

Verification
REQ-036 Reset, pulse i_game_start -> o_brick_load 1 cycle later, o_life_count=3, o_stage=1, o_ball_hold=1.
REQ-037 In SERVE, no i_shoot, 180 ticks -> single o_ball_launch, state PLAY.
REQ-038 Three i_life_loss cycles (PAUSE_FRAMES each) -> lives 2,1,0, then o_game_over=1, o_win=0.
REQ-039 i_life_loss and i_stage_clear same cycle at stage 1 -> lives 3, stage 2 after 60 ticks, o_brick_load pulse.
REQ-040 Clear stage 8 -> o_game_over=1, o_win=1; i_game_start -> stage 1, lives 3.
REQ-041 i_rst_n low mid-LOST -> immediate IDLE, all outputs 0.
